// File: rtl/io_uart_tx_dma.sv
// DMA sequencer streaming bytes from the 64-byte IO memory to the UART transmitter.
// CPU programs BASE/LEN/CTRL; the CPU always wins the shared memory read port.
module io_uart_tx_dma #(
    parameter int unsigned Width    = 32,
    parameter int unsigned AddrW    = 6,
    parameter int unsigned REG_BASE = 'h40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_we,
    input  logic [Width-1:0] cpu_addr,
    input  logic [Width-1:0] cpu_wdata,
    output logic [Width-1:0] cpu_rdata,
    input  logic             cpu_mem_busy,
    output logic             mem_sel,
    output logic [AddrW-1:0] mem_addr,
    input  logic [7:0]       mem_rdata,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             irq
);

    localparam int unsigned LenW = 8;
    localparam logic [Width-1:0] ADDR_BASE = Width'(REG_BASE);
    localparam logic [Width-1:0] ADDR_LEN  = Width'(REG_BASE + 4);
    localparam logic [Width-1:0] ADDR_CTRL = Width'(REG_BASE + 8);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t            state_q, state_d;
    logic [AddrW-1:0]  base_q, base_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [AddrW-1:0]  ptr_q, ptr_d;
    logic [LenW-1:0]   cnt_q, cnt_d;
    logic              ie_q, ie_d;
    logic              done_q, done_d;
    logic              abort_pend_q, abort_pend_d;
    logic [7:0]        tx_data_d;
    logic              tx_valid_d;
    logic              irq_d;

    logic busy, wr_base, wr_len, wr_ctrl, start_req, abort_req;
    logic unused_wdata;

    assign busy      = (state_q != IDLE);
    assign wr_base   = cpu_we && (cpu_addr == ADDR_BASE);
    assign wr_len    = cpu_we && (cpu_addr == ADDR_LEN);
    assign wr_ctrl   = cpu_we && (cpu_addr == ADDR_CTRL);
    assign start_req = wr_ctrl && cpu_wdata[0];
    assign abort_req = wr_ctrl && cpu_wdata[1];
    assign unused_wdata = ^cpu_wdata[Width-1:LenW];

    // Memory port is only claimed in cycles the CPU leaves it free
    assign mem_sel  = (state_q == FETCH) && !cpu_mem_busy;
    assign mem_addr = ptr_q;

    always_comb begin
        cpu_rdata = '0;
        if (cpu_addr == ADDR_BASE) begin
            cpu_rdata = Width'(base_q);
        end else if (cpu_addr == ADDR_LEN) begin
            cpu_rdata = Width'(len_q);
        end else if (cpu_addr == ADDR_CTRL) begin
            cpu_rdata = Width'({busy, done_q, ie_q, 2'b00});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            ie_q         <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            irq          <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            ie_q         <= ie_d;
            done_q       <= done_d;
            abort_pend_q <= abort_pend_d;
            tx_data      <= tx_data_d;
            tx_valid     <= tx_valid_d;
            irq          <= irq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        ie_d         = ie_q;
        done_d       = done_q;
        abort_pend_d = abort_pend_q;
        tx_data_d    = tx_data;
        tx_valid_d   = tx_valid;

        if (wr_base && !busy) base_d = cpu_wdata[AddrW-1:0];
        if (wr_len && !busy)  len_d  = cpu_wdata[LenW-1:0];
        if (wr_ctrl) begin
            ie_d = cpu_wdata[2];
            if (cpu_wdata[3]) done_d = 1'b0;
        end

        // FSM updates come last so a DONE set outranks a same-cycle clear
        case (state_q)
            IDLE: begin
                if (start_req && !abort_req) begin
                    ptr_d = base_q;
                    cnt_d = len_q;
                    if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (!cpu_mem_busy) begin
                    tx_data_d  = mem_rdata;
                    tx_valid_d = 1'b1;
                    ptr_d      = ptr_q + AddrW'(1);
                    cnt_d      = cnt_q - LenW'(1);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (abort_req) abort_pend_d = 1'b1;
                if (tx_ready) begin
                    tx_valid_d   = 1'b0;
                    abort_pend_d = 1'b0;
                    if (abort_req || abort_pend_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        irq_d = done_d && ie_d;
    end

endmodule

// File: tb/tb_io_uart_tx_dma.sv
// Self-checking bench for io_uart_tx_dma: byte-queue reference model plus directed and random transfers.
module tb_io_uart_tx_dma;

    localparam logic [31:0] A_BASE = 32'h40;
    localparam logic [31:0] A_LEN  = 32'h44;
    localparam logic [31:0] A_CTRL = 32'h48;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_mem_busy;
    logic        mem_sel;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    logic [7:0] mem [64];
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    io_uart_tx_dma dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_mem_busy (cpu_mem_busy),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .irq          (irq)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sent[$];
    bit rnd_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare: CPU priority, SEND hold stability, and each handshaken byte against the model
    logic       pv = 1'b0;
    logic       ph = 1'b0;
    logic [7:0] pd = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            ph = 1'b0;
        end else begin
            chk("cpu_priority", 32'(mem_sel && cpu_mem_busy), 32'd0);
            if (pv && !ph) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(pd));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_extra: got byte %h, required no byte (t=%0t)", tx_data, $time);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                sent.push_back(tx_data);
            end
            pv = tx_valid;
            pd = tx_data;
            ph = tx_valid && tx_ready;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd_en) begin
            tx_ready     = ($urandom_range(0, 9) < 7);
            cpu_mem_busy = ($urandom_range(0, 9) < 3);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        cyc();
        cpu_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        cpu_addr = a;
        #1;
        d = cpu_rdata;
    endtask

    task automatic expect_xfer(input int b, input int l);
        for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % 64]);
    endtask

    task automatic setup(input int b, input int l);
        sent.delete();
        expect_xfer(b, l);
        wr(A_BASE, 32'(b));
        wr(A_LEN, 32'(l));
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        int k = 0;
        rd(A_CTRL, s);
        while (s[4] && k < budget) begin
            cyc();
            rd(A_CTRL, s);
            k++;
        end
        chk("idle_reached", 32'(s[4]), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        rst = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_mem_busy = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_mem_sel", 32'(mem_sel), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd(A_CTRL, s); chk("rst_status", s, 32'h0);
        rd(A_BASE, s); chk("rst_base", s, 32'h0);
        rd(32'h4C, s); chk("unmapped_read", s, 32'h0);
        rst = 1'b0;
        cyc();

        // Basic transfer with first-byte latency
        tx_ready = 1'b1;
        setup(4, 3);
        wr(A_CTRL, 32'h1);
        chk("first_valid_early", 32'(tx_valid), 32'd0);
        cyc();
        chk("first_valid", 32'(tx_valid), 32'd1);
        chk("first_data", 32'(tx_data), 32'd4);
        wait_idle(50);
        chk("t1_count", 32'(sent.size()), 32'd3);
        if (sent.size() == 3) begin
            chk("t1_b0", 32'(sent[0]), 32'd4);
            chk("t1_b1", 32'(sent[1]), 32'd5);
            chk("t1_b2", 32'(sent[2]), 32'd6);
        end
        rd(A_CTRL, s); chk("t1_status", s, 32'h08);

        // Address wrap 63 -> 0
        setup(62, 4);
        wr(A_CTRL, 32'h1);
        wait_idle(50);
        chk("t2_count", 32'(sent.size()), 32'd4);
        if (sent.size() == 4) begin
            chk("t2_b0", 32'(sent[0]), 32'd62);
            chk("t2_b1", 32'(sent[1]), 32'd63);
            chk("t2_b2", 32'(sent[2]), 32'd0);
            chk("t2_b3", 32'(sent[3]), 32'd1);
        end

        // CPU holds the memory for 5 cycles during FETCH
        setup(10, 2);
        cpu_mem_busy = 1'b1;
        wr(A_CTRL, 32'h1);
        repeat (5) begin
            chk("stall_mem_sel", 32'(mem_sel), 32'd0);
            chk("stall_no_valid", 32'(tx_valid), 32'd0);
            cyc();
        end
        cpu_mem_busy = 1'b0;
        wait_idle(50);
        chk("t3_b0", 32'(sent.size() > 0 ? sent[0] : 8'hFF), 32'd10);

        // Backpressure: byte held stable for 10 cycles
        tx_ready = 1'b0;
        setup(20, 2);
        wr(A_CTRL, 32'h1);
        cyc();
        repeat (10) begin
            chk("bp_valid", 32'(tx_valid), 32'd1);
            chk("bp_data", 32'(tx_data), 32'd20);
            cyc();
        end
        tx_ready = 1'b1;
        wait_idle(50);
        chk("t4_count", 32'(sent.size()), 32'd2);

        // LEN=0: DONE without any byte
        wr(A_CTRL, 32'h8);
        rd(A_CTRL, s); chk("w1c_done", s, 32'h0);
        setup(0, 0);
        wr(A_CTRL, 32'h1);
        repeat (4) begin
            chk("len0_no_valid", 32'(tx_valid), 32'd0);
            cyc();
        end
        rd(A_CTRL, s); chk("len0_status", s, 32'h08);
        chk("len0_count", 32'(sent.size()), 32'd0);

        // ABORT in SEND under backpressure; START and BASE writes while busy are ignored
        tx_ready = 1'b0;
        setup(30, 5);
        wr(A_CTRL, 32'h1);
        cyc();
        chk("t5_valid", 32'(tx_valid), 32'd1);
        wr(A_CTRL, 32'h1);
        wr(A_BASE, 32'h0);
        rd(A_BASE, s); chk("base_locked", s, 32'd30);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        wr(A_CTRL, 32'h2);
        repeat (3) begin
            chk("abort_hold_valid", 32'(tx_valid), 32'd1);
            cyc();
        end
        tx_ready = 1'b1;
        wait_idle(50);
        rd(A_CTRL, s); chk("abort_status", s, 32'h0);
        chk("abort_count", 32'(sent.size()), 32'd1);

        // ABORT in FETCH: nothing sent
        setup(40, 3);
        cpu_mem_busy = 1'b1;
        wr(A_CTRL, 32'h1);
        exp_q.delete();
        wr(A_CTRL, 32'h2);
        cpu_mem_busy = 1'b0;
        wait_idle(50);
        chk("fetch_abort_count", 32'(sent.size()), 32'd0);

        // START+ABORT together in IDLE
        setup(40, 3);
        exp_q.delete();
        wr(A_CTRL, 32'h3);
        repeat (3) cyc();
        rd(A_CTRL, s); chk("start_abort_status", s, 32'h0);
        chk("start_abort_count", 32'(sent.size()), 32'd0);

        // Interrupt and W1C
        setup(0, 2);
        wr(A_CTRL, 32'h5);
        wait_idle(50);
        chk("irq_set", 32'(irq), 32'd1);
        rd(A_CTRL, s); chk("irq_status", s, 32'h0C);
        wr(A_CTRL, 32'hC);
        chk("irq_clear", 32'(irq), 32'd0);
        rd(A_CTRL, s); chk("irq_clr_status", s, 32'h04);

        // Async reset in SEND
        tx_ready = 1'b0;
        setup(5, 3);
        wr(A_CTRL, 32'h5);
        cyc();
        chk("pre_rst_valid", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(tx_valid), 32'd0);
        chk("arst_data", 32'(tx_data), 32'd0);
        chk("arst_mem_sel", 32'(mem_sel), 32'd0);
        rd(A_CTRL, s); chk("arst_status", s, 32'h0);
        exp_q.delete();
        cyc();
        rst = 1'b0;
        cyc();

        // Random transfers with random backpressure, CPU contention, IE and aborts
        rnd_en = 1'b1;
        for (int it = 0; it < 30; it++) begin
            int b, l;
            bit ie, aborted;
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            b = int'($urandom_range(0, 63));
            l = (it % 7 == 0) ? 0 : int'($urandom_range(1, 12));
            ie = 1'($urandom_range(0, 1));
            aborted = 1'b0;
            setup(b, l);
            wr(A_CTRL, 32'h1 | (32'(ie) << 2));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 6)) cyc();
                rd(A_CTRL, s);
                if (s[4]) begin
                    while (exp_q.size() > (tx_valid ? 1 : 0)) void'(exp_q.pop_back());
                    wr(A_CTRL, 32'h2 | (32'(ie) << 2));
                    aborted = 1'b1;
                end
            end
            wait_idle(3000);
            rd(A_CTRL, s);
            chk("rnd_status", s, (aborted ? 32'h0 : 32'h8) | (32'(ie) << 2));
            chk("rnd_irq", 32'(irq), 32'(ie && !aborted));
            wr(A_CTRL, 32'h8 | (32'(ie) << 2));
            chk("rnd_irq_clr", 32'(irq), 32'd0);
        end
        rnd_en = 1'b0;
        cpu_mem_busy = 1'b0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
